dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
- Parametrised data memory with an integrated RISC-V load/store front end; next generation of the core's word-only RAM.
- Adds byte/halfword/word access with byte-lane writes, sign/zero extension, alignment and range fault reporting, and a synchronous one-cycle read with a valid/ready handshake.
- Adds a sequential clear-on-reset engine.
- Sits between the pipeline MEM stage and the storage array; synthesised register storage, single port.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; power of two, 4..8192.
- CLEAR_ON_RESET, 1, 1: zero every word after reset, one word per cycle. 0: skip clearing, contents undefined.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends (lbu/lhu); ignored for word and stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result, extended; 0 for stores and faults.
- rsp_err  out  1  fault flag, valid with rsp_valid.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset, sampled at posedge with rst_n=0:
  - state=INIT, clear pointer=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - busy=1 if CLEAR_ON_RESET=1, else 0.
- States: INIT, IDLE.
- INIT with CLEAR_ON_RESET=1:
  - Each cycle after rst_n rises, write 0 to word[ptr] and increment ptr.
  - After writing word DEPTH_WORDS-1, go to IDLE.
  - busy=1 and req_ready=0 for exactly DEPTH_WORDS cycles after reset release.
- INIT with CLEAR_ON_RESET=0: go to IDLE on the first cycle after release.
- IDLE: req_ready=1 and busy=0 every cycle. Throughput is one request per cycle.
- Accept happens when req_valid && req_ready.
  - Word index = req_addr[log2(DEPTH_WORDS)+1:2].
  - Lane = req_addr[1:0].
- Fault, checked in priority-free OR; any of the following sets rsp_err=1:
  - req_size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - req_addr >= 4*DEPTH_WORDS (out of range).
  - On fault: no write occurs, rsp_rdata=0.
- Store (no fault):
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes written.
  - Unselected lanes are unchanged. Write commits at the accept edge.
- Load (no fault):
  - Select byte or half from the stored word at the lane.
  - Sign-extend from bit 7/15 unless req_unsigned=1, then zero-extend. Word loads pass through.
- Latency:
  - rsp_valid=1 exactly on the cycle after accept, for one cycle; 0 otherwise.
  - Stores also respond (ack) with rdata=0.
  - No response backpressure; the consumer must take it.
- Read-after-write:
  - A load accepted the cycle after a store to the same word returns the updated data.
  - Back-to-back requests are independent; each gets its own response one cycle later.
- Reset mid-operation:
  - An in-flight response is dropped, so rsp_valid=0 in the cycle after reset is sampled.
  - A clear already in progress restarts from ptr=0.
  - A request presented during reset or INIT is ignored and must be held by the requester.
- Out of range: the pointer and index never wrap into valid storage; out-of-range addresses only fault.

Test Plan:
- Release reset with DEPTH_WORDS=16 and CLEAR_ON_RESET=1 -> busy=1 and req_ready=0 for 16 cycles, then req_ready=1; lw of every address 0..60 returns 0 with err=0.
- sw 0x8BADF00D @0x8; then lb @0x8, lbu @0x8, lh @0xA, lhu @0xA, lb @0xB -> rdata 0x0000000D, 0x0000000D, 0xFFFF8BAD, 0x00008BAD, 0xFFFFFF8B; each rsp_valid one cycle after accept.
- sw 0x11223344 @0x4, sb 0xAA @0x5, sh 0xBEEF @0x6, then lw @0x4 -> 0xBEEFAA44.
- sh @0x3, lw @0x2, size=11 @0x0, lw @0x40 with DEPTH_WORDS=16 -> each gives rsp_err=1 and rdata=0; a following lw @0x0 shows memory unchanged.
- Continuous alternating sw/lw to the same word every cycle -> rsp_valid high every cycle, each load returns the preceding store's data.
- Assert rst_n=0 for one cycle midway through the clear and again with a load in flight -> no rsp_valid after reset; clear restarts, busy high for the full DEPTH_WORDS cycles.

Source files
------------

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Purpose  : Single-port data memory with a RISC-V load/store front end.
//            Byte/half/word accesses with byte-lane writes, sign/zero
//            extension of loads, alignment and range fault reporting, a
//            registered one-cycle response and an optional sequential clear
//            of the whole array after reset.
// Ports    : clk          - clock, all logic on posedge
//            rst_n        - synchronous active-low reset
//            req_valid    - request present
//            req_ready    - request can be accepted this cycle
//            req_we       - 1 = store, 0 = load
//            req_size     - 00 byte, 01 half, 10 word, 11 illegal
//            req_unsigned - zero-extend sub-word loads
//            req_addr     - byte address
//            req_wdata    - right-aligned store data
//            rsp_valid    - one-cycle response strobe
//            rsp_rdata    - extended load data (0 for stores and faults)
//            rsp_err      - fault flag, qualified by rsp_valid
//            busy         - clear sequence in progress
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int DEPTH_WORDS    = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int                 c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH_WORDS - 1);
    localparam logic [c_IDX_W-1:0] c_ONE   = c_IDX_W'(1);
    localparam logic [1:0]         c_SZ_B  = 2'b00;
    localparam logic [1:0]         c_SZ_H  = 2'b01;
    localparam logic [1:0]         c_SZ_W  = 2'b10;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] w_ptr_next;
    logic               w_clear_en;

    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;

    logic               w_accept;
    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_lane;
    logic               w_oor;
    logic               w_fault;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_clear_en   = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (CLEAR_ON_RESET) begin
                    w_clear_en = 1'b1;
                    w_ptr_next = r_ptr + c_ONE;
                    if (r_ptr == c_LAST) begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // Qualified by rst_n so a request presented while reset is asserted is
    // never seen as accepted by the requester.
    assign req_ready = (r_state == ST_IDLE) && rst_n;
    assign busy      = CLEAR_ON_RESET && (r_state == ST_INIT);
    assign w_accept  = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_idx  = req_addr[c_IDX_W+1:2];
    assign w_lane = req_addr[1:0];
    // Any set bit above the array span faults; the truncated index is then
    // never used for a write and the read data is discarded.
    assign w_oor  = (req_addr[31:c_IDX_W+2] != '0);

    assign w_fault = (req_size == 2'b11)
                   | ((req_size == c_SZ_H) && req_addr[0])
                   | ((req_size == c_SZ_W) && (req_addr[1:0] != 2'b00))
                   | w_oor;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = req_wdata;
        case (req_size)
            c_SZ_B: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{req_wdata[7:0]}};
            end
            c_SZ_H: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            c_SZ_W: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = req_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: clear engine and byte-lane stores share the single port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clear_en) begin
                r_mem[r_ptr] <= '0;
            end else if (w_accept && req_we && !w_fault) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and extension
    // ------------------------------------------------------------------
    assign w_word = r_mem[w_idx];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_lane)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        w_load = '0;
        case (req_size)
            c_SZ_B:  w_load = req_unsigned ? {24'h0, w_byte}
                                           : {{24{w_byte[7]}}, w_byte};
            c_SZ_H:  w_load = req_unsigned ? {16'h0, w_half}
                                           : {{16{w_half[15]}}, w_half};
            c_SZ_W:  w_load = w_word;
            default: w_load = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_err   <= w_accept && w_fault;
            r_rsp_rdata <= (w_accept && !req_we && !w_fault) ? w_load : '0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
